// File: rtl/acc_shift_ctrl.sv
// acc_shift_ctrl: sequences one accumulator operation at a time into the load/store
//   shifter, splitting every multi-bit shift or rotate into single-bit steps, one per clock.
// Ports: clk/rst (sync active-high); req_valid/req_ready/req_op/req_amt/req_fill request
//   handshake; acc_q shifter feedback; sh_* shifter controls; busy/done status.
// Latency: k-bit shift -> done in cycle k+1; LOAD/CLR/SET -> 2; NOP or amt=0 -> 1.
//   req_ready is low for the whole operation, so request fields are ignored while busy.
module acc_shift_ctrl #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_amt,
  input  logic          req_fill,
  input  logic [N-1:0]  acc_q,
  output logic [1:0]    sh_ctrl,
  output logic [2:0]    sh_num,
  output logic          sh_ls,
  output logic          sh_rs,
  output logic          sh_clr_n,
  output logic          sh_set_n,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_SET  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_r;
  logic [AW-1:0] cnt;
  logic          fill_r;
  logic          accept;

  // Only the edge bits of the accumulator matter (rotate feedback).
  logic unused_acc_mid;
  assign unused_acc_mid = ^acc_q[N-2:1];

  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= OP_NOP;
      cnt    <= '0;
      fill_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r   <= req_op;
        cnt    <= req_amt;
        fill_r <= req_fill;
      end else if (state == SHIFT) begin
        cnt <= cnt - AW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_LOAD, OP_CLR, OP_SET:         state_nxt = ISSUE;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR:  state_nxt = (req_amt != '0) ? SHIFT : DONE;
            default:                         state_nxt = DONE;
          endcase
        end
      end
      ISSUE:   state_nxt = DONE;
      // cnt still holds the number of steps left including the current one.
      SHIFT:   state_nxt = (cnt == AW'(1)) ? DONE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifter controls are combinational so the shifter acts on the edge that
  // leaves ISSUE/SHIFT; rotates sample the live edge bit for every step.
  always_comb begin
    sh_ctrl  = 2'b00;
    sh_num   = 3'd0;
    sh_ls    = 1'b0;
    sh_rs    = 1'b0;
    sh_clr_n = 1'b1;
    sh_set_n = 1'b1;
    if (state == ISSUE) begin
      case (op_r)
        OP_LOAD: sh_ctrl  = 2'b01;
        OP_CLR:  sh_clr_n = 1'b0;
        OP_SET:  sh_set_n = 1'b0;
        default: ;
      endcase
    end else if (state == SHIFT) begin
      sh_num = 3'd1;
      case (op_r)
        OP_SHL: begin sh_ctrl = 2'b10; sh_ls = fill_r;     end
        OP_SHR: begin sh_ctrl = 2'b11; sh_rs = fill_r;     end
        OP_ROL: begin sh_ctrl = 2'b10; sh_ls = acc_q[N-1]; end
        OP_ROR: begin sh_ctrl = 2'b11; sh_rs = acc_q[0];   end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_acc_shift_ctrl.sv
// Testbench for acc_shift_ctrl: a behavioural 8-bit shifter closes the loop on acc_q;
// stimulus pushes hand-computed expectations, a negedge monitor pops them on done.
module tb_acc_shift_ctrl;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
  localparam logic [2:0] ROL = 3'd4, ROR = 3'd5, CLR = 3'd6, SET = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [2:0] req_amt = 3'd0;
  logic       req_fill = 1'b0;
  logic [7:0] acc_q = 8'h00;
  logic [7:0] ld_dat = 8'h00;
  logic [1:0] sh_ctrl;
  logic [2:0] sh_num;
  logic       sh_ls, sh_rs, sh_clr_n, sh_set_n, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] acc;
    int         lat;
    int         act;
  } exp_t;
  exp_t exp_q[$];

  acc_shift_ctrl #(.N(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_amt(req_amt), .req_fill(req_fill), .acc_q(acc_q),
    .sh_ctrl(sh_ctrl), .sh_num(sh_num), .sh_ls(sh_ls), .sh_rs(sh_rs),
    .sh_clr_n(sh_clr_n), .sh_set_n(sh_set_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural shifter driven by the controller outputs.
  always @(posedge clk) begin
    if (!sh_clr_n)      acc_q <= 8'h00;
    else if (!sh_set_n) acc_q <= 8'hFF;
    else if (sh_ctrl == 2'b01) acc_q <= ld_dat;
    else if (sh_ctrl == 2'b10 && sh_num == 3'd1) acc_q <= {acc_q[6:0], sh_ls};
    else if (sh_ctrl == 2'b11 && sh_num == 3'd1) acc_q <= {sh_rs, acc_q[7:1]};
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: all sampling on the falling edge.
  logic       pend = 1'b0, in_op = 1'b0;
  logic [2:0] pend_op, op_c;
  logic       pend_fill, fill_c;
  int         cyc = 0, act = 0;

  always @(negedge clk) begin
    logic active;
    logic [5:0] want_dir;
    if (pend) begin
      in_op = 1'b1; cyc = 0; act = 0; op_c = pend_op; fill_c = pend_fill; pend = 1'b0;
    end
    if (in_op) cyc++;
    chk("ready_vs_busy", {31'd0, req_ready}, {31'd0, !busy});
    active = (sh_ctrl != 2'b00) || !sh_clr_n || !sh_set_n;
    if (active) begin
      act++;
      if (!in_op) chk("shifter_pulse_outside_op", 32'd1, 32'd0);
    end
    if (sh_ctrl[1]) begin
      want_dir[5:4] = (op_c == SHL || op_c == ROL) ? 2'b10 : 2'b11;
      want_dir[3:1] = 3'd1;
      want_dir[0]   = (op_c == SHL || op_c == SHR) ? fill_c :
                      (op_c == ROL) ? acc_q[7] : acc_q[0];
      chk("shift_step_ctrl_num_fill",
          {26'd0, sh_ctrl, sh_num, (sh_ctrl[0] ? sh_rs : sh_ls)}, {26'd0, want_dir});
      chk("shift_unused_fill_zero", {31'd0, sh_ctrl[0] ? sh_ls : sh_rs}, 32'd0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_acc", {24'd0, acc_q}, {24'd0, e.acc});
        chk("done_latency", cyc, e.lat);
        chk("shifter_active_cycles", act, e.act);
      end
      in_op = 1'b0;
    end
    if (rst) in_op = 1'b0;
    pend      = req_valid && req_ready && !rst;
    pend_op   = req_op;
    pend_fill = req_fill;
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("timeout_waiting_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    // Scramble request fields while busy: they must be ignored.
    while (busy && n < 50) begin
      req_op = 3'($urandom); req_amt = 3'($urandom); req_fill = 1'($urandom);
      @(posedge clk); #1; n++;
    end
    if (busy) chk("timeout_waiting_idle", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [2:0] amt, input logic fill,
                       input logic [7:0] ld, input logic [7:0] eacc, input int elat,
                       input int eact);
    exp_t e;
    wait_ready();
    e.acc = eacc; e.lat = elat; e.act = eact;
    exp_q.push_back(e);
    ld_dat = ld; req_op = op; req_amt = amt; req_fill = fill; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    exp_t e;
    // Reset for two edges, then check idle output values.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sh_idle", {23'd0, sh_ctrl, sh_num, sh_ls, sh_rs, sh_clr_n, sh_set_n},
        {23'd0, 9'b00_000_0011});
    rst = 1'b0;
    @(posedge clk); #1;

    // {op, amt, fill, load data, expected acc, latency, shifter-active cycles}
    do_op(CLR,  3'd0, 1'b0, 8'h00, 8'h00, 2, 1);
    do_op(SET,  3'd0, 1'b0, 8'h00, 8'hFF, 2, 1);
    do_op(LOAD, 3'd0, 1'b0, 8'h5A, 8'h5A, 2, 1);
    do_op(LOAD, 3'd0, 1'b0, 8'hB4, 8'hB4, 2, 1);
    do_op(SHL,  3'd3, 1'b1, 8'h00, 8'hA7, 4, 3);
    do_op(LOAD, 3'd0, 1'b0, 8'h81, 8'h81, 2, 1);
    do_op(ROR,  3'd7, 1'b0, 8'h00, 8'h03, 8, 7);

    // SHR amt=0 then NOP with req_valid held high: done one cycle after each accept.
    wait_ready();
    e.acc = 8'h03; e.lat = 1; e.act = 0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    req_op = SHR; req_amt = 3'd0; req_fill = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = NOP; req_amt = 3'd5;
    @(posedge clk); #1;
    chk("b2b_second_accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();

    do_op(LOAD, 3'd0, 1'b0, 8'h96, 8'h96, 2, 1);
    do_op(ROL,  3'd2, 1'b0, 8'h00, 8'h5A, 3, 2);
    do_op(SHR,  3'd2, 1'b1, 8'h00, 8'hD6, 3, 2);
    do_op(LOAD, 3'd0, 1'b0, 8'h81, 8'h81, 2, 1);

    // ROL 5 abandoned by a two-cycle reset after three steps: 81 -> 03 -> 06 -> 0C.
    wait_ready();
    req_op = ROL; req_amt = 3'd5; req_fill = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 1'b1; req_op = LOAD; ld_dat = 8'hEE;
    @(posedge clk); #1;
    chk("abort_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_done_low", {31'd0, done}, 32'd0);
    chk("abort_sh_idle", {23'd0, sh_ctrl, sh_num, sh_ls, sh_rs, sh_clr_n, sh_set_n},
        {23'd0, 9'b00_000_0011});
    chk("abort_acc_partial", {24'd0, acc_q}, 32'h0C);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_acc_frozen", {24'd0, acc_q}, 32'h0C);
    chk("all_expected_dones_seen", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acc_shift_ctrl.md
Name: acc_shift_ctrl

Overview:
Sequencer for the accumulator's load/store shifter register. It accepts one accumulator operation at a time from the processor control unit over a valid/ready handshake. It then drives the shifter's control pins (ctrl, num_shift, Ls, Rs, clr, set) and breaks every multi-bit shift into single-bit steps, one per clock. Single-bit steps make rotates possible by feeding the accumulator's own edge bit back as the fill bit, and give the control unit a deterministic busy/done indication.

Parameters:
N, 8, accumulator width; must match the shifter width.
AW, 3, width of the shift-amount field (max amount 2^AW-1 = 7).

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  control unit presents an operation.
req_ready  out  1  controller can accept; high only in IDLE.
req_op  in  3  operation code. 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 CLR, 111 SET.
req_amt  in  AW  shift/rotate amount; ignored for non-shift ops.
req_fill  in  1  fill bit for SHL/SHR.
acc_q  in  N  current shifter register output; used for rotate feedback.
sh_ctrl  out  2  to shifter ctrl: 00 hold, 01 load, 10 left, 11 right.
sh_num  out  3  to shifter num_shift.
sh_ls  out  1  to shifter Ls.
sh_rs  out  1  to shifter Rs.
sh_clr_n  out  1  to shifter clr (active low).
sh_set_n  out  1  to shifter set (active low).
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the operation is complete.

Behaviour:
- States: IDLE, ISSUE, SHIFT, DONE. State encoding is free.
- Registered state: state, op_r (3 bits), cnt (AW bits), fill_r.
- Reset (rst=1 at a clock edge):
  - state=IDLE, cnt=0, op_r=NOP, fill_r=0.
  - Reset is honoured from any state and takes priority over everything else; an operation in progress is abandoned with no done pulse.
  - Outputs after reset: req_ready=1, busy=0, done=0, sh_ctrl=00, sh_num=0, sh_ls=0, sh_rs=0, sh_clr_n=1, sh_set_n=1.
  - The accumulator contents are not touched by controller reset.
- Accept: on an edge with state=IDLE and req_valid=1, latch op_r, cnt=req_amt and fill_r. req_* values are don't-care in every other state.
- Transitions out of IDLE on accept:
  - LOAD, CLR, SET -> ISSUE.
  - SHL, SHR, ROL, ROR with req_amt!=0 -> SHIFT.
  - NOP, or any shift op with req_amt=0 -> DONE directly; the shifter is never pulsed.
- ISSUE: lasts exactly 1 cycle, then DONE. Drives:
  - LOAD: sh_ctrl=01.
  - CLR: sh_clr_n=0.
  - SET: sh_set_n=0.
- SHIFT: drives sh_num=1 every cycle; cnt decrements each edge. When cnt=1 at an edge, next state is DONE; otherwise stay in SHIFT. Exactly req_amt single-bit steps are issued. Per op:
  - SHL: sh_ctrl=10, sh_ls=fill_r.
  - SHR: sh_ctrl=11, sh_rs=fill_r.
  - ROL: sh_ctrl=10, sh_ls=acc_q[N-1].
  - ROR: sh_ctrl=11, sh_rs=acc_q[0].
- DONE: done=1, busy=1, shifter outputs at idle values. Next state is IDLE.
- Output timing: all sh_* outputs are combinational from state, op_r, fill_r and acc_q, with no extra register stage, so the shifter acts on the same edge that leaves ISSUE/SHIFT. Outside ISSUE/SHIFT every sh_* output holds its idle value.
- Latency from the accept edge:
  - k-bit shift: SHIFT occupies cycles 1..k, done is high in cycle k+1, req_ready returns in cycle k+2.
  - LOAD/CLR/SET: done in cycle 2.
  - NOP or amt=0: done in cycle 1.
  - Back-to-back throughput is therefore one operation per (latency+1) cycles.
- Simultaneous events: rst=1 together with req_valid=1 in IDLE means no accept. req_valid held high continuously means the next operation is accepted on the first IDLE edge.

Test Plan:
- rst=1 for 2 cycles mid-SHIFT of ROL 5 -> next cycle state IDLE, req_ready=1, done never pulses, sh_* idle, acc_q frozen at its partial value.
- acc_q preloaded 8'hB4 via LOAD; SHL amt=3, fill=1 -> 3 SHIFT cycles with sh_ctrl=10, sh_num=1; acc_q=8'hA7; done on cycle 4 after accept.
- acc_q=8'h81; ROR amt=7 -> acc_q=8'h03 (rotate right 7 = rotate left 1); sh_rs tracks acc_q[0] each step; done exactly once.
- SHR amt=0 then NOP back-to-back with req_valid held high -> each gives done one cycle after accept, sh_ctrl stays 00 throughout, acc_q unchanged.
- CLR then SET then LOAD 8'h5A -> sh_clr_n=0, then sh_set_n=0, then sh_ctrl=01, each for exactly one cycle; acc_q sequence is 00, FF, 5A; req_ready=0 while busy=1.
- req_op/req_amt toggled randomly while busy -> results identical to the values latched at accept.
